// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO frame/iteration scheduler.
package siso_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CFG,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } sched_state_t;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_BLKLEN = 2'd1;
  localparam logic [1:0] ERR_WDOG   = 2'd2;

  localparam int SISO_TAIL       = 3;
  localparam int SISO_MIN_BLKLEN = 40;
  localparam int SISO_MAX_BLKLEN = 6144;

endpackage

// File: rtl/siso_sched_rdgen.sv
// Read address/strobe generator for the input and a-priori RAMs, plus the
// one-cycle pipeline that aligns RAM read data with the core valid strobes.
module siso_sched_rdgen
  import siso_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int TAIL   = SISO_TAIL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              first_iter,
  input  logic [ADDR_W-1:0] blklen,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              apr_rd_en,
  output logic [ADDR_W-1:0] apr_rd_addr,
  input  logic [DATA_W-1:0] apr_rd_data,
  output logic [DATA_W-1:0] dec_in,
  output logic              dec_valid_in,
  output logic [DATA_W-1:0] dec_apriori,
  output logic              dec_valid_apriori,
  output logic              stream_last
);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vin_q, vin_d;
  logic              last_q, last_d;
  logic              apr_v_q, apr_v_d;
  logic              apr_zero_q, apr_zero_d;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] step;
  logic              apr_beat;

  always_comb begin
    last_addr  = ((blklen + ADDR_W'(TAIL)) << 1) - ADDR_W'(1);
    step       = addr_q >> 1;
    // An a-priori beat rides along with each parity read of a data step.
    apr_beat   = active_q && addr_q[0] && (step < blklen);
    active_d   = active_q;
    addr_d     = addr_q;
    if (start) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (active_q) begin
      if (addr_q == last_addr) begin
        active_d = 1'b0;
        addr_d   = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
    vin_d      = active_q;
    last_d     = active_q && (addr_q == last_addr);
    apr_v_d    = apr_beat;
    apr_zero_d = first_iter;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= 1'b0;
      addr_q     <= '0;
      vin_q      <= 1'b0;
      last_q     <= 1'b0;
      apr_v_q    <= 1'b0;
      apr_zero_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      addr_q     <= addr_d;
      vin_q      <= vin_d;
      last_q     <= last_d;
      apr_v_q    <= apr_v_d;
      apr_zero_q <= apr_zero_d;
    end
  end

  // First half-iteration has no prior extrinsics, so the core gets zeros.
  assign in_rd_en          = active_q;
  assign in_rd_addr        = addr_q;
  assign apr_rd_en         = apr_beat && !first_iter;
  assign apr_rd_addr       = apr_rd_en ? step : '0;
  assign dec_valid_in      = vin_q;
  assign dec_in            = vin_q ? in_rd_data : '0;
  assign dec_valid_apriori = apr_v_q;
  assign dec_apriori       = (apr_v_q && !apr_zero_q) ? apr_rd_data : '0;
  assign stream_last       = last_q;

endmodule

// File: rtl/siso_sched.sv
// Frame/iteration controller for the SISO decoder core: validates a block
// command, configures the core, streams RAM data in and extrinsics back out.
module siso_sched
  import siso_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 14,
  parameter int MAX_BLKLEN = SISO_MAX_BLKLEN,
  parameter int MIN_BLKLEN = SISO_MIN_BLKLEN,
  parameter int TAIL       = SISO_TAIL,
  parameter int WDOG_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_blklen,
  input  logic [3:0]        cmd_iters,
  output logic              done,
  output logic [1:0]        err,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              apr_rd_en,
  output logic [ADDR_W-1:0] apr_rd_addr,
  input  logic [DATA_W-1:0] apr_rd_data,
  output logic              ext_wr_en,
  output logic [ADDR_W-1:0] ext_wr_addr,
  output logic [DATA_W-1:0] ext_wr_data,
  output logic [DATA_W-1:0] dec_in,
  output logic              dec_valid_in,
  output logic [DATA_W-1:0] dec_apriori,
  output logic              dec_valid_apriori,
  output logic [15:0]       dec_blklen,
  output logic              dec_valid_blklen,
  input  logic [DATA_W-1:0] dec_extrinsic,
  input  logic              dec_valid_extrinsic,
  input  logic              dec_ready,
  output logic [3:0]        iter_cnt
);

  if (2 * (MAX_BLKLEN + TAIL) >= (1 << ADDR_W)) begin : g_addr_w_check
    $error("ADDR_W is too narrow for 2*(MAX_BLKLEN+TAIL) input beats");
  end

  sched_state_t      state_q, state_d;
  logic [15:0]       blklen_q, blklen_d;
  logic [3:0]        n_iters_q, n_iters_d;
  logic [3:0]        iter_cnt_q, iter_cnt_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W-1:0] ext_cnt_q, ext_cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              cfg_pulse_q, cfg_pulse_d;
  logic [ADDR_W-1:0] k_addr;
  logic              blk_ok;
  logic              wdog_run;
  logic              wdog_expired;
  logic              stream_last;

  assign k_addr       = ADDR_W'(blklen_q);
  assign blk_ok       = (blklen_q >= 16'(MIN_BLKLEN)) && (blklen_q <= 16'(MAX_BLKLEN)) &&
                        (blklen_q[2:0] == 3'd0);
  assign wdog_run     = (state_q == S_CFG) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign wdog_expired = &wdog_q;

  // Extrinsics may start arriving before the input stream finishes.
  assign ext_wr_en   = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                       dec_valid_extrinsic && (ext_cnt_q < k_addr);
  assign ext_wr_addr = ext_wr_en ? ext_cnt_q : '0;
  assign ext_wr_data = ext_wr_en ? dec_extrinsic : '0;

  always_comb begin
    state_d     = state_q;
    blklen_d    = blklen_q;
    n_iters_d   = n_iters_q;
    iter_cnt_d  = iter_cnt_q;
    err_d       = err_q;
    cfg_pulse_d = 1'b0;
    ext_cnt_d   = ext_wr_en ? (ext_cnt_q + ADDR_W'(1)) : ext_cnt_q;
    wdog_d      = wdog_q;
    if (!wdog_run || dec_valid_in || dec_valid_extrinsic) begin
      wdog_d = '0;
    end else if (!wdog_expired) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          blklen_d   = cmd_blklen;
          n_iters_d  = (cmd_iters == 4'd0) ? 4'd1 : cmd_iters;
          iter_cnt_d = 4'd0;
          err_d      = ERR_OK;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!blk_ok) begin
          err_d   = ERR_BLKLEN;
          state_d = S_FIN;
        end else begin
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        ext_cnt_d = '0;
        if (wdog_expired) begin
          err_d   = ERR_WDOG;
          state_d = S_FIN;
        end else if (dec_ready) begin
          cfg_pulse_d = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (wdog_expired) begin
          err_d   = ERR_WDOG;
          state_d = S_FIN;
        end else if (stream_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ext_cnt_q == k_addr) begin
          if (({1'b0, iter_cnt_q} + 5'd1) < {1'b0, n_iters_q}) begin
            iter_cnt_d = iter_cnt_q + 4'd1;
            state_d    = S_CFG;
          end else begin
            err_d   = ERR_OK;
            state_d = S_FIN;
          end
        end else if (wdog_expired) begin
          err_d   = ERR_WDOG;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      blklen_q    <= '0;
      n_iters_q   <= '0;
      iter_cnt_q  <= '0;
      err_q       <= ERR_OK;
      ext_cnt_q   <= '0;
      wdog_q      <= '0;
      cfg_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blklen_q    <= blklen_d;
      n_iters_q   <= n_iters_d;
      iter_cnt_q  <= iter_cnt_d;
      err_q       <= err_d;
      ext_cnt_q   <= ext_cnt_d;
      wdog_q      <= wdog_d;
      cfg_pulse_q <= cfg_pulse_d;
    end
  end

  assign cmd_ready        = (state_q == S_IDLE);
  assign done             = (state_q == S_FIN);
  assign err              = err_q;
  assign iter_cnt         = iter_cnt_q;
  assign dec_valid_blklen = cfg_pulse_q;
  assign dec_blklen       = cfg_pulse_q ? blklen_q : '0;

  // Reads start the cycle after the configuration pulse.
  siso_sched_rdgen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TAIL   (TAIL)
  ) u_rdgen (
    .clk               (clk),
    .rst               (rst),
    .start             (cfg_pulse_q),
    .first_iter        (iter_cnt_q == 4'd0),
    .blklen            (k_addr),
    .in_rd_en          (in_rd_en),
    .in_rd_addr        (in_rd_addr),
    .in_rd_data        (in_rd_data),
    .apr_rd_en         (apr_rd_en),
    .apr_rd_addr       (apr_rd_addr),
    .apr_rd_data       (apr_rd_data),
    .dec_in            (dec_in),
    .dec_valid_in      (dec_valid_in),
    .dec_apriori       (dec_apriori),
    .dec_valid_apriori (dec_valid_apriori),
    .stream_last       (stream_last)
  );

endmodule

// File: tb/tb_siso_sched.sv
// Directed bench for siso_sched: RAM models plus a scripted core model,
// with one task per scenario doing its own comparisons.
module tb_siso_sched;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int WDOG_W = 6;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_blklen;
  logic [3:0]        cmd_iters;
  logic              done;
  logic [1:0]        err;
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_rd_addr;
  logic [DATA_W-1:0] in_rd_data;
  logic              apr_rd_en;
  logic [ADDR_W-1:0] apr_rd_addr;
  logic [DATA_W-1:0] apr_rd_data;
  logic              ext_wr_en;
  logic [ADDR_W-1:0] ext_wr_addr;
  logic [DATA_W-1:0] ext_wr_data;
  logic [DATA_W-1:0] dec_in;
  logic              dec_valid_in;
  logic [DATA_W-1:0] dec_apriori;
  logic              dec_valid_apriori;
  logic [15:0]       dec_blklen;
  logic              dec_valid_blklen;
  logic [DATA_W-1:0] dec_extrinsic;
  logic              dec_valid_extrinsic;
  logic              dec_ready;
  logic [3:0]        iter_cnt;

  siso_sched #(.WDOG_W(WDOG_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_blklen          (cmd_blklen),
    .cmd_iters           (cmd_iters),
    .done                (done),
    .err                 (err),
    .in_rd_en            (in_rd_en),
    .in_rd_addr          (in_rd_addr),
    .in_rd_data          (in_rd_data),
    .apr_rd_en           (apr_rd_en),
    .apr_rd_addr         (apr_rd_addr),
    .apr_rd_data         (apr_rd_data),
    .ext_wr_en           (ext_wr_en),
    .ext_wr_addr         (ext_wr_addr),
    .ext_wr_data         (ext_wr_data),
    .dec_in              (dec_in),
    .dec_valid_in        (dec_valid_in),
    .dec_apriori         (dec_apriori),
    .dec_valid_apriori   (dec_valid_apriori),
    .dec_blklen          (dec_blklen),
    .dec_valid_blklen    (dec_valid_blklen),
    .dec_extrinsic       (dec_extrinsic),
    .dec_valid_extrinsic (dec_valid_extrinsic),
    .dec_ready           (dec_ready),
    .iter_cnt            (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input RAM holds 0x1000 + address; a-priori RAM is a real 64-entry array.
  logic [DATA_W-1:0] apr_mem [0:63];
  always @(posedge clk) begin
    if (in_rd_en) in_rd_data <= 16'h1000 + 16'(in_rd_addr);
    if (apr_rd_en) apr_rd_data <= apr_mem[apr_rd_addr[5:0]];
    if (ext_wr_en) apr_mem[ext_wr_addr[5:0]] <= ext_wr_data;
  end

  int tests = 0;
  int fails = 0;

  int st_pulses, st_pulse_cyc, st_first_rd_cyc, st_blklen_bad;
  int st_vin, st_vin_bad, st_apr, st_apr_bad, st_aprrd, st_aprrd_bad;
  int st_wr, st_wr_bad, st_done, st_done_cyc, st_last_ext_cyc, st_ready_busy;
  int st_iter_at_pulse [0:3];
  logic [1:0] st_err;

  // Runs one command with a scripted core; records what it observed.
  task automatic run_block(input int k, input int iters, input int emit_n,
                           input int ready_delay, input bit hold_cmd, input int budget);
    int pass, j, a, ra, w, e, total;
    bit emitting;
    logic [DATA_W-1:0] exp_apr;
    st_pulses = 0; st_pulse_cyc = -1; st_first_rd_cyc = -1; st_blklen_bad = 0;
    st_vin = 0; st_vin_bad = 0; st_apr = 0; st_apr_bad = 0; st_aprrd = 0; st_aprrd_bad = 0;
    st_wr = 0; st_wr_bad = 0; st_done = 0; st_done_cyc = -1; st_last_ext_cyc = -1;
    st_ready_busy = 0; st_err = 2'd3;
    for (int i = 0; i < 4; i++) st_iter_at_pulse[i] = -1;
    total = 2 * (k + 3);
    pass = -1; j = 0; a = 0; ra = 0; w = 0; e = 0; emitting = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      cmd_valid  = (cyc == 0) || hold_cmd;
      cmd_blklen = 16'(k);
      cmd_iters  = 4'(iters);
      dec_ready  = (cyc >= ready_delay);
      if (emitting && e < emit_n) begin
        dec_valid_extrinsic = 1'b1;
        dec_extrinsic = 16'h5000 + 16'(pass * 256 + e);
        st_last_ext_cyc = cyc;
        e++;
      end else begin
        dec_valid_extrinsic = 1'b0;
        dec_extrinsic = '0;
      end
      #1;
      if (cyc > 0 && cmd_ready) st_ready_busy++;
      if (dec_valid_blklen) begin
        st_pulses++;
        if (st_pulses == 1) st_pulse_cyc = cyc;
        if (dec_blklen !== 16'(k)) st_blklen_bad++;
        pass++;
        if (pass < 4) st_iter_at_pulse[pass] = int'(iter_cnt);
        j = 0; a = 0; ra = 0; w = 0;
      end
      if (in_rd_en && st_first_rd_cyc < 0) st_first_rd_cyc = cyc;
      if (apr_rd_en) begin
        st_aprrd++;
        if (apr_rd_addr !== ADDR_W'(ra)) st_aprrd_bad++;
        ra++;
      end
      if (dec_valid_apriori) begin
        st_apr++;
        exp_apr = (pass == 0) ? 16'h0000 : 16'h5000 + 16'((pass - 1) * 256 + a);
        if (!(dec_valid_in && (j % 2 == 1)) || dec_apriori !== exp_apr) st_apr_bad++;
        a++;
      end
      if (dec_valid_in) begin
        if (dec_in !== 16'h1000 + 16'(j)) st_vin_bad++;
        st_vin++;
        j++;
        if (j == total) begin
          emitting = 1'b1;
          e = 0;
        end
      end else if (j > 0 && j < total) begin
        st_vin_bad++;
      end
      if (ext_wr_en) begin
        st_wr++;
        if (ext_wr_addr !== ADDR_W'(w) || ext_wr_data !== 16'h5000 + 16'(pass * 256 + w))
          st_wr_bad++;
        w++;
      end
      if (done) begin
        st_done++;
        st_err = err;
        st_done_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    dec_valid_extrinsic = 1'b0;
    dec_extrinsic = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
    tests++;
    if ({done, err, in_rd_en, in_rd_addr, apr_rd_en, apr_rd_addr, ext_wr_en, ext_wr_addr, ext_wr_data,
         dec_in, dec_valid_in, dec_apriori, dec_valid_apriori, dec_blklen, dec_valid_blklen, iter_cnt} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs_zero: got nonzero outputs (in_rd_en=%0b dec_valid_blklen=%0b done=%0b) expected all 0",
                        in_rd_en, dec_valid_blklen, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_pass();
    run_block(40, 1, 40, 0, 1'b0, 600);
    tests++; if (st_done !== 1) begin fails++; $display("[TB] FAIL single_done: got %0d expected 1 (timeout)", st_done); end
    tests++; if (st_err !== 2'd0) begin fails++; $display("[TB] FAIL single_err: got %0d expected 0", st_err); end
    tests++; if (st_pulses !== 1 || st_blklen_bad !== 0) begin fails++; $display("[TB] FAIL single_cfg: got %0d pulses, %0d bad blklen expected 1, 0", st_pulses, st_blklen_bad); end
    tests++; if (st_pulse_cyc !== 3) begin fails++; $display("[TB] FAIL single_cfg_cycle: got %0d expected 3", st_pulse_cyc); end
    tests++; if (st_vin !== 86 || st_vin_bad !== 0) begin fails++; $display("[TB] FAIL single_input: got %0d beats, %0d bad expected 86, 0", st_vin, st_vin_bad); end
    tests++; if (st_apr !== 40 || st_apr_bad !== 0 || st_aprrd !== 0) begin fails++; $display("[TB] FAIL single_apriori: got %0d beats, %0d bad, %0d reads expected 40, 0, 0", st_apr, st_apr_bad, st_aprrd); end
    tests++; if (st_wr !== 40 || st_wr_bad !== 0) begin fails++; $display("[TB] FAIL single_ext_write: got %0d writes, %0d bad expected 40, 0", st_wr, st_wr_bad); end
  endtask

  task automatic test_two_pass();
    run_block(48, 2, 50, 0, 1'b0, 1200);
    tests++; if (st_done !== 1 || st_err !== 2'd0) begin fails++; $display("[TB] FAIL two_done: got done %0d err %0d expected 1, 0", st_done, st_err); end
    tests++; if (st_pulses !== 2) begin fails++; $display("[TB] FAIL two_cfg_pulses: got %0d expected 2", st_pulses); end
    tests++; if (st_iter_at_pulse[0] !== 0 || st_iter_at_pulse[1] !== 1) begin fails++; $display("[TB] FAIL two_iter_cnt: got %0d,%0d expected 0,1", st_iter_at_pulse[0], st_iter_at_pulse[1]); end
    tests++; if (st_vin !== 204 || st_vin_bad !== 0) begin fails++; $display("[TB] FAIL two_input: got %0d beats, %0d bad expected 204, 0", st_vin, st_vin_bad); end
    tests++; if (st_aprrd !== 48 || st_aprrd_bad !== 0) begin fails++; $display("[TB] FAIL two_apr_reads: got %0d reads, %0d bad expected 48, 0", st_aprrd, st_aprrd_bad); end
    tests++; if (st_apr !== 96 || st_apr_bad !== 0) begin fails++; $display("[TB] FAIL two_apriori: got %0d beats, %0d bad expected 96, 0", st_apr, st_apr_bad); end
    tests++; if (st_wr !== 96 || st_wr_bad !== 0) begin fails++; $display("[TB] FAIL two_ext_write: got %0d writes, %0d bad expected 96, 0", st_wr, st_wr_bad); end
  endtask

  task automatic test_bad_blklen();
    int lens [3] = '{16, 6152, 44};
    for (int i = 0; i < 3; i++) begin
      run_block(lens[i], 1, 0, 0, 1'b0, 20);
      tests++; if (st_done !== 1 || st_err !== 2'd1) begin fails++; $display("[TB] FAIL bad_blklen_%0d: got done %0d err %0d expected 1, 1", lens[i], st_done, st_err); end
      tests++; if (st_done_cyc < 0 || st_done_cyc > 3) begin fails++; $display("[TB] FAIL bad_blklen_%0d_latency: got %0d cycles expected <= 3", lens[i], st_done_cyc); end
      tests++; if (st_pulses !== 0) begin fails++; $display("[TB] FAIL bad_blklen_%0d_cfg: got %0d pulses expected 0", lens[i], st_pulses); end
    end
  endtask

  task automatic test_ready_stall();
    run_block(40, 1, 40, 50, 1'b0, 800);
    tests++; if (st_pulse_cyc !== 51 || st_pulses !== 1) begin fails++; $display("[TB] FAIL stall_cfg: got pulse at %0d (%0d pulses) expected 51 (1)", st_pulse_cyc, st_pulses); end
    tests++; if (st_first_rd_cyc !== 52) begin fails++; $display("[TB] FAIL stall_stream_start: got %0d expected 52", st_first_rd_cyc); end
    tests++; if (st_done !== 1 || st_err !== 2'd0) begin fails++; $display("[TB] FAIL stall_done: got done %0d err %0d expected 1, 0", st_done, st_err); end
  endtask

  task automatic test_watchdog();
    run_block(40, 1, 39, 0, 1'b0, 400);
    tests++; if (st_done !== 1 || st_err !== 2'd2) begin fails++; $display("[TB] FAIL wdog_err: got done %0d err %0d expected 1, 2", st_done, st_err); end
    tests++; if (st_done_cyc - st_last_ext_cyc !== 65) begin fails++; $display("[TB] FAIL wdog_delay: got %0d expected 65", st_done_cyc - st_last_ext_cyc); end
    tests++; if (st_wr !== 39) begin fails++; $display("[TB] FAIL wdog_writes: got %0d expected 39", st_wr); end
  endtask

  task automatic test_cmd_ignored();
    run_block(40, 0, 40, 0, 1'b1, 600);
    tests++; if (st_pulses !== 1) begin fails++; $display("[TB] FAIL busy_cfg_pulses: got %0d expected 1", st_pulses); end
    tests++; if (st_ready_busy !== 0) begin fails++; $display("[TB] FAIL busy_cmd_ready: got %0d ready cycles expected 0", st_ready_busy); end
    tests++; if (st_done !== 1 || st_err !== 2'd0 || st_vin !== 86) begin fails++; $display("[TB] FAIL busy_done: got done %0d err %0d beats %0d expected 1, 0, 86", st_done, st_err, st_vin); end
  endtask

  task automatic test_mid_reset();
    int nb = 0;
    int seen_done = 0;
    bit hit = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      cmd_valid  = (cyc == 0);
      cmd_blklen = 16'd40;
      cmd_iters  = 4'd1;
      dec_ready  = 1'b1;
      #1;
      if (dec_valid_in) begin
        if (nb == 20) begin
          hit = 1'b1;
          break;
        end
        nb++;
      end
    end
    tests++; if (!hit) begin fails++; $display("[TB] FAIL midrst_reach_beat: got %0d beats expected 21", nb); end
    rst = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_cmd_ready: got %0b expected 1", cmd_ready); end
    tests++;
    if ({done, err, in_rd_en, in_rd_addr, apr_rd_en, apr_rd_addr, ext_wr_en, ext_wr_addr, ext_wr_data,
         dec_in, dec_valid_in, dec_apriori, dec_valid_apriori, dec_blklen, dec_valid_blklen, iter_cnt} !== '0) begin
      fails++; $display("[TB] FAIL midrst_outputs_zero: got in_rd_en=%0b dec_valid_in=%0b dec_in=%0h expected all 0",
                        in_rd_en, dec_valid_in, dec_in);
    end
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #1;
      if (done) seen_done++;
    end
    tests++; if (seen_done !== 0) begin fails++; $display("[TB] FAIL midrst_no_done: got %0d done pulses expected 0", seen_done); end
    run_block(40, 1, 40, 0, 1'b0, 600);
    tests++; if (st_pulse_cyc !== 3 || st_done !== 1 || st_err !== 2'd0) begin fails++; $display("[TB] FAIL midrst_restart: got pulse %0d done %0d err %0d expected 3, 1, 0", st_pulse_cyc, st_done, st_err); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_blklen = '0;
    cmd_iters = '0;
    dec_extrinsic = '0;
    dec_valid_extrinsic = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_pass();
    test_two_pass();
    test_bad_blklen();
    test_ready_stall();
    test_watchdog();
    test_cmd_ignored();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
